// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IF/MEM memory-port arbiter.
// Owner encoding is derived from the FSM state via owner_of().
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    localparam int MAX_DM_RUN_DEF = 4;
    localparam int TIMEOUT_DEF    = 16;

    function automatic owner_e owner_of(state_e s);
        return (s == BUSY_DM) ? OWN_DM : OWN_IF;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Backend memory port: req/ack transaction bus.
// master = arbiter side, slave = memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/mem_arb_watchdog.sv
// Backend timeout counter with sticky error flag.
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic busy_i,
    input  logic ack_i,
    output logic expire_o,
    output logic err_o
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic          err_q;

    assign expire_o = busy_i & ~ack_i & (cnt_q == LAST);
    assign err_o    = err_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (!busy_i || ack_i || expire_o)
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + 1'b1;
            if (expire_o)
                err_q <= 1'b1;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IF and MEM stages with DM-first priority.
// Optional backend timeout: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_DM_RUN = MAX_DM_RUN_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    output logic              if_stall_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              dm_stall_o,
    mem_port_arbiter_if.master mem,
    output logic              err_o
);
    localparam int RW = $clog2(MAX_DM_RUN + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(MAX_DM_RUN);

    state_e            state_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
    logic              if_ack_q, dm_ack_q;
    logic [RW-1:0]     dm_run_q, dm_run_d;
    logic              gnt_dm, gnt_if;
    logic              busy, done, expire;

    assign busy = (state_q != IDLE);
    assign done = busy & (mem.ack | expire);

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .busy_i   (busy),
        .ack_i    (mem.ack),
        .expire_o (expire),
        .err_o    (err_o)
    );
`else
    assign expire = 1'b0;
    assign err_o  = 1'b0;
`endif

    // No grant in an ack-pulse cycle, so a held req is never reissued
    // and the masked requester does not lose its turn to the other one.
    always_comb begin
        gnt_dm   = 1'b0;
        gnt_if   = 1'b0;
        dm_run_d = dm_run_q;
        if (!busy && !if_ack_q && !dm_ack_q) begin
            gnt_dm = dm_req_i & (~if_req_i | (dm_run_q != RUN_MAX));
            gnt_if = if_req_i & ~gnt_dm;
        end
        if (gnt_dm)
            dm_run_d = !if_req_i ? '0 :
                       (dm_run_q == RUN_MAX) ? dm_run_q :
                       dm_run_q + 1'b1;
        else if (gnt_if)
            dm_run_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
            dm_run_q   <= '0;
        end else begin
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            dm_run_q <= dm_run_d;
            unique case (state_q)
                IDLE: begin
                    if (gnt_dm) begin
                        state_q <= BUSY_DM;
                        we_q    <= dm_we_i;
                        addr_q  <= dm_addr_i;
                        wdata_q <= dm_wdata_i;
                    end else if (gnt_if) begin
                        state_q <= BUSY_IF;
                        we_q    <= 1'b0;
                        addr_q  <= if_addr_i;
                        wdata_q <= '0;
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    if (done) begin
                        state_q <= IDLE;
                        if (owner_of(state_q) == OWN_IF) begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= mem.ack ? mem.rdata : '0;
                        end else begin
                            dm_ack_q <= 1'b1;
                            if (!we_q)
                                dm_rdata_q <= mem.ack ? mem.rdata : '0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem.req    = busy;
    assign mem.we     = we_q;
    assign mem.addr   = addr_q;
    assign mem.wdata  = wdata_q;
    assign if_rdata_o = if_rdata_q;
    assign dm_rdata_o = dm_rdata_q;
    assign if_ack_o   = if_ack_q;
    assign dm_ack_o   = dm_ack_q;
    assign if_stall_o = if_req_i & ~if_ack_q;
    assign dm_stall_o = dm_req_i & ~dm_ack_q;
endmodule
